ins_mem_readback: RTL
=====================

Name: ins_mem_readback

Overview:
- Debug readback engine on the instruction-memory read port; the counterpart of the instruction write-load port (InsWrEN/InsWrAddr/InsDataIn).
- Used while the CPU is held in clear. It walks an inclusive address range, reads each instruction word and presents it on a valid/ready stream.
- Accumulates an XOR checksum and a word count, so a loaded program can be confirmed before the CPU is released.

Parameters:
- ADDR_W, 5, instruction-memory address width (32 words).
- DATA_W, 32, instruction word width.
- RD_LAT, 1, instruction-memory read latency in cycles, legal range 1..3.

Ports:
- clk  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; ignored unless IDLE.
- abort  in  1  stop the walk; return to IDLE without done.
- StartAddr  in  ADDR_W  first address, sampled on an accepted start.
- EndAddr  in  ADDR_W  last address (inclusive), sampled on an accepted start.
- InsRdEN  out  1  memory read strobe.
- InsRdAddr  out  ADDR_W  memory read address.
- InsDataOut  in  DATA_W  memory read data, valid RD_LAT cycles after InsRdEN.
- DumpValid  out  1  stream beat valid.
- DumpReady  in  1  stream sink ready.
- DumpAddr  out  ADDR_W  address of the current beat.
- DumpData  out  DATA_W  word of the current beat.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal completion.
- Checksum  out  DATA_W  XOR of all accepted beats.
- WordCnt  out  ADDR_W+1  number of accepted beats.

Behaviour:
- Reset: all outputs 0, state IDLE, internal ptr/end/data registers 0. RST asserted mid-walk returns to IDLE immediately; no done pulse.
- FSM states: IDLE, ISSUE, WAIT, HOLD, DONE.
- IDLE:
  - start=1 latches ptr<=StartAddr and end<=EndAddr, clears Checksum and WordCnt, then goes to ISSUE.
  - Checksum and WordCnt otherwise hold their last values.
- ISSUE (exactly 1 cycle): InsRdEN=1, InsRdAddr=ptr, load latency counter with RD_LAT, go to WAIT. InsRdEN is 0 in all other states; InsRdAddr holds ptr.
- WAIT (RD_LAT cycles): on the last WAIT cycle, capture InsDataOut into the data register, then go to HOLD.
- HOLD:
  - DumpValid=1, DumpAddr=ptr, DumpData=data register; all three stay stable until the handshake.
  - On handshake (DumpValid&&DumpReady): Checksum^=data, WordCnt+=1.
  - If ptr==end go to DONE, else ptr<=ptr+1 mod 2^ADDR_W and go to ISSUE.
  - DumpValid never drops without a handshake, except on abort or RST.
- DONE (1 cycle): done=1, busy=1, then IDLE.
- Latency with RD_LAT=1 and DumpReady tied high, start accepted at edge 0:
  - ISSUE in cycle 1, WAIT in cycle 2, HOLD in cycle 3.
  - Each word costs 2+RD_LAT cycles.
- Range rules:
  - StartAddr==EndAddr gives one word.
  - StartAddr>EndAddr wraps 31->0; e.g. 30..1 gives 30,31,0,1.
  - Full ring (start=0, end=31) gives 32 words with WordCnt=32, so no overflow.
- Simultaneous events:
  - abort has priority over a handshake in the same cycle: that beat is not counted, and the next state is IDLE.
  - start while busy is ignored.
  - start together with abort in IDLE: start wins.
- Back-pressure: DumpReady low for any length keeps the FSM in HOLD; no re-read is issued.

Decomposition:
- Shared package mips_dbg_pkg holds the state enum type, the ADDR_W/DATA_W defaults and the RD_LAT legal range constants.
- No sub-module; the block is a single FSM plus datapath registers.
- The bench supplies a behavioural instruction memory with a write port and a registered read port of RD_LAT cycles.

Test Plan:
- Preload mem[1]=0x00211020 and mem[2]=0x00221820, DumpReady=1, walk 1..2 -> beats (1,0x00211020) then (2,0x00221820); Checksum=0x00030800, WordCnt=2, one done pulse.
- Preload mem[17]=0x08000009, walk 17..17, RD_LAT=1 -> InsRdEN in cycle 1, DumpValid in cycle 3, done in cycle 4, WordCnt=1.
- Walk 30..1 with mem[a]=a -> beat addresses 30,31,0,1; Checksum=0x0000001E^0x1F^0x00^0x01=0x00000000; WordCnt=4.
- Walk 0..31, DumpReady low for 5 cycles during beat 3 -> DumpAddr/DumpData stable throughout; no extra InsRdEN; WordCnt=32.
- Abort in HOLD of beat 2 with DumpReady=1 in the same cycle -> IDLE next cycle, no done, WordCnt=1; a start pulse during the walk has no effect.
- Assert RST in WAIT -> all outputs 0 at once; a fresh start after release runs a correct walk; repeat with RD_LAT=3.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug blocks: default memory geometry,
// the legal instruction-memory read latency range and the readback FSM states.
package mips_dbg_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // Wide enough to hold any legal read latency value
    localparam int LAT_CNT_W = $clog2(RD_LAT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        DONE
    } readbackState_t;

endpackage

// File: rtl/ins_mem_readback.sv
// Instruction-memory readback engine: while the CPU is held in clear it walks
// an inclusive (possibly wrapping) address range, streams each word out on a
// valid/ready port and keeps an XOR checksum plus a count of accepted words.
module ins_mem_readback
    import mips_dbg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [ADDR_W-1:0] EndAddr,
    output logic              InsRdEN,
    output logic [ADDR_W-1:0] InsRdAddr,
    input  logic [DATA_W-1:0] InsDataOut,
    output logic              DumpValid,
    input  logic              DumpReady,
    output logic [ADDR_W-1:0] DumpAddr,
    output logic [DATA_W-1:0] DumpData,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Checksum,
    output logic [ADDR_W:0]   WordCnt
);

    readbackState_t state;
    readbackState_t nextState;

    logic [ADDR_W-1:0]    ptr;
    logic [ADDR_W-1:0]    endAddr;
    logic [DATA_W-1:0]    dataReg;
    logic [LAT_CNT_W-1:0] latCnt;

    logic acceptStart;
    logic lastWait;
    logic beatTaken;

    // start is only honoured in IDLE, and there it beats a simultaneous abort;
    // an abort in HOLD suppresses the handshake so the beat is not counted
    assign acceptStart = (state == IDLE) && start;
    assign lastWait    = (state == WAIT) && (latCnt == LAT_CNT_W'(1));
    assign beatTaken   = (state == HOLD) && DumpReady && !abort;

    // State register
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: abort pulls every active state straight back to IDLE
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                nextState = abort ? IDLE : WAIT;
            end
            WAIT: begin
                if (abort) begin
                    nextState = IDLE;
                end else if (lastWait) begin
                    nextState = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    nextState = IDLE;
                end else if (DumpReady) begin
                    nextState = (ptr == endAddr) ? DONE : ISSUE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Moore outputs; the beat fields are forced to zero outside HOLD
    always_comb begin
        InsRdEN   = (state == ISSUE);
        InsRdAddr = ptr;
        DumpValid = (state == HOLD);
        DumpAddr  = (state == HOLD) ? ptr : '0;
        DumpData  = (state == HOLD) ? dataReg : '0;
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

    // Datapath: range pointers, latency countdown, captured word and totals
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ptr      <= '0;
            endAddr  <= '0;
            dataReg  <= '0;
            latCnt   <= '0;
            Checksum <= '0;
            WordCnt  <= '0;
        end else begin
            if (acceptStart) begin
                ptr      <= StartAddr;
                endAddr  <= EndAddr;
                Checksum <= '0;
                WordCnt  <= '0;
            end

            if (state == ISSUE) begin
                latCnt <= LAT_CNT_W'(RD_LAT);
            end else if ((state == WAIT) && (latCnt != '0)) begin
                latCnt <= latCnt - LAT_CNT_W'(1);
            end

            if (lastWait) begin
                dataReg <= InsDataOut;
            end

            if (beatTaken) begin
                Checksum <= Checksum ^ dataReg;
                WordCnt  <= WordCnt + (ADDR_W + 1)'(1);
                if (ptr != endAddr) begin
                    ptr <= ptr + ADDR_W'(1);
                end
            end
        end
    end

endmodule
